// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition trigger block.
// Holds the FSM state encoding and the trig_type codes.
package acq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned TRIG_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_A  = 3'd1,
    ST_WAIT_B  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_READY   = 3'd4
  } acq_state_e;

  // Code 3 is not listed; it behaves like TRIG_IMM.
  localparam logic [TRIG_W-1:0] TRIG_IMM  = 2'd0;
  localparam logic [TRIG_W-1:0] TRIG_RISE = 2'd1;
  localparam logic [TRIG_W-1:0] TRIG_FALL = 2'd2;

endpackage

// File: rtl/acq_trig_detect.sv
// Combinational edge detector for one word of NSAMP signed samples.
// Ports:
//   s_data       NSAMP*SW packed samples, sample 0 in the LSBs (oldest)
//   lower_thresh signed lower threshold
//   upper_thresh signed upper threshold
//   falling      1: A = above upper, B = below lower; 0: the reverse
//   any_a        some sample meets condition A
//   any_b        some sample meets condition B
//   a_then_b     a B sample sits at a strictly later index than an A sample
module acq_trig_detect #(
  parameter int unsigned NSAMP = 10,
  parameter int unsigned SW    = 12
) (
  input  logic [NSAMP*SW-1:0] s_data,
  input  logic [SW-1:0]       lower_thresh,
  input  logic [SW-1:0]       upper_thresh,
  input  logic                falling,
  output logic                any_a,
  output logic                any_b,
  output logic                a_then_b
);

  logic lo;
  logic hi;
  logic ca;
  logic cb;

  // any_a is tested before it absorbs the current sample, so B must follow A.
  always_comb begin
    any_a    = 1'b0;
    any_b    = 1'b0;
    a_then_b = 1'b0;
    lo       = 1'b0;
    hi       = 1'b0;
    ca       = 1'b0;
    cb       = 1'b0;
    for (int i = 0; i < int'(NSAMP); i++) begin
      lo = $signed(s_data[i*SW +: SW]) < $signed(lower_thresh);
      hi = $signed(s_data[i*SW +: SW]) > $signed(upper_thresh);
      ca = falling ? hi : lo;
      cb = falling ? lo : hi;
      if (cb && any_a) a_then_b = 1'b1;
      any_a = any_a | ca;
      any_b = any_b | cb;
    end
  end

endmodule

// File: rtl/acq_trigger.sv
// Event acquisition trigger: waits for an immediate, rising or falling
// threshold crossing, then writes up to length_to_take words to a FIFO.
// Optional feature: define ACQ_AUTOTRIG_EN to enable the wait-state timeout
// that forces a capture after timeout_cycles clocks.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   s_data, s_valid           sample word stream
//   arm                       start a new event (IDLE only)
//   trig_type                 0 immediate, 1 rising, 2 falling, 3 as 0
//   lower_thresh/upper_thresh signed thresholds
//   length_to_take            words to capture
//   timeout_cycles            auto-trigger timeout (ACQ_AUTOTRIG_EN only)
//   fifo_full                 downstream back-pressure
//   readout_done              host finished reading the event
//   fifo_wr, fifo_wdata       registered FIFO write port
//   event_ready, words_taken, event_count, truncated, auto_trig, state
module acq_trigger
  import acq_pkg::*;
#(
  parameter int unsigned NSAMP = 10,
  parameter int unsigned SW    = 12,
  parameter int unsigned CW    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NSAMP*SW-1:0] s_data,
  input  logic                s_valid,
  input  logic                arm,
  input  logic [1:0]          trig_type,
  input  logic [SW-1:0]       lower_thresh,
  input  logic [SW-1:0]       upper_thresh,
  input  logic [CW-1:0]       length_to_take,
  input  logic [CW-1:0]       timeout_cycles,
  input  logic                fifo_full,
  input  logic                readout_done,
  output logic                fifo_wr,
  output logic [NSAMP*SW-1:0] fifo_wdata,
  output logic                event_ready,
  output logic [CW-1:0]       words_taken,
  output logic [CW-1:0]       event_count,
  output logic                truncated,
  output logic                auto_trig,
  output logic [2:0]          state
);

  localparam int unsigned W = NSAMP * SW;

  acq_state_e    state_q, state_d;
  logic [1:0]    trig_q, trig_d;
  logic [SW-1:0] lower_q, lower_d;
  logic [SW-1:0] upper_q, upper_d;
  logic [CW-1:0] length_q, length_d;
  logic [CW-1:0] words_q, words_d;
  logic [CW-1:0] evcnt_q, evcnt_d;
  logic          ev_ready_q, ev_ready_d;
  logic          trunc_q, trunc_d;
  logic          auto_q, auto_d;
  logic          wr_q, wr_d;
  logic [W-1:0]  wdata_q, wdata_d;

  logic falling;
  logic any_a;
  logic any_b;
  logic a_then_b;
  logic tmo_hit;

  assign falling = (trig_q == TRIG_FALL);

  // Crossing detection on the incoming word using the latched thresholds.
  acq_trig_detect #(
    .NSAMP(NSAMP),
    .SW   (SW)
  ) u_detect (
    .s_data      (s_data),
    .lower_thresh(lower_q),
    .upper_thresh(upper_q),
    .falling     (falling),
    .any_a       (any_a),
    .any_b       (any_b),
    .a_then_b    (a_then_b)
  );

`ifdef ACQ_AUTOTRIG_EN
  // Wait-state timeout counter; spans WAIT_A and WAIT_B, cleared on arm.
  logic [CW-1:0] tmo_cnt_q;
  logic          in_wait;

  assign in_wait = (state_q == ST_WAIT_A) || (state_q == ST_WAIT_B);
  assign tmo_hit = in_wait && (timeout_cycles != '0) &&
                   (tmo_cnt_q == timeout_cycles - CW'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && arm) begin
      tmo_cnt_q <= '0;
    end else if (in_wait) begin
      tmo_cnt_q <= tmo_cnt_q + CW'(1);
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = ^timeout_cycles;
  assign tmo_hit    = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    trig_d     = trig_q;
    lower_d    = lower_q;
    upper_d    = upper_q;
    length_d   = length_q;
    words_d    = words_q;
    evcnt_d    = evcnt_q;
    ev_ready_d = ev_ready_q;
    trunc_d    = trunc_q;
    auto_d     = auto_q;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          trig_d   = trig_type;
          lower_d  = lower_thresh;
          upper_d  = upper_thresh;
          length_d = length_to_take;
          words_d  = '0;
          trunc_d  = 1'b0;
          auto_d   = 1'b0;
          state_d  = ((trig_type == TRIG_RISE) || (trig_type == TRIG_FALL)) ?
                     ST_WAIT_A : ST_CAPTURE;
        end
      end
      ST_WAIT_A: begin
        if (s_valid && a_then_b) begin
          state_d = ST_CAPTURE;
        end else if (tmo_hit) begin
          state_d = ST_CAPTURE;
          auto_d  = 1'b1;
        end else if (s_valid && any_a) begin
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (s_valid && any_b) begin
          state_d = ST_CAPTURE;
        end else if (tmo_hit) begin
          state_d = ST_CAPTURE;
          auto_d  = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Completion wins over back-pressure; a full FIFO only truncates.
        if (words_q == length_q) begin
          state_d    = ST_READY;
          ev_ready_d = 1'b1;
          evcnt_d    = evcnt_q + CW'(1);
        end else if (fifo_full) begin
          state_d    = ST_READY;
          trunc_d    = 1'b1;
          ev_ready_d = 1'b1;
          evcnt_d    = evcnt_q + CW'(1);
        end else if (s_valid) begin
          wr_d    = 1'b1;
          wdata_d = s_data;
          words_d = words_q + CW'(1);
        end
      end
      ST_READY: begin
        if (readout_done) begin
          ev_ready_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      trig_q     <= '0;
      lower_q    <= '0;
      upper_q    <= '0;
      length_q   <= '0;
      words_q    <= '0;
      evcnt_q    <= '0;
      ev_ready_q <= 1'b0;
      trunc_q    <= 1'b0;
      auto_q     <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      lower_q    <= lower_d;
      upper_q    <= upper_d;
      length_q   <= length_d;
      words_q    <= words_d;
      evcnt_q    <= evcnt_d;
      ev_ready_q <= ev_ready_d;
      trunc_q    <= trunc_d;
      auto_q     <= auto_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign fifo_wr     = wr_q;
  assign fifo_wdata  = wdata_q;
  assign event_ready = ev_ready_q;
  assign words_taken = words_q;
  assign event_count = evcnt_q;
  assign truncated   = trunc_q;
  assign auto_trig   = auto_q;
  assign state       = state_q;

endmodule

// File: tb/tb_acq_trigger.sv
// Self-checking bench for acq_trigger. Expected FIFO words go into a queue
// when driven; a negedge monitor pops and compares on every fifo_wr.
// CW is reduced to 10 so the event counter wrap fits a short run.
module tb_acq_trigger;
  import acq_pkg::*;

  localparam int unsigned NSAMP = 10;
  localparam int unsigned SW    = 12;
  localparam int unsigned CW    = 10;
  localparam int unsigned W     = NSAMP * SW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          arm;
  logic [1:0]    trig_type;
  logic [SW-1:0] lower_thresh;
  logic [SW-1:0] upper_thresh;
  logic [CW-1:0] length_to_take;
  logic [CW-1:0] timeout_cycles;
  logic          fifo_full;
  logic          readout_done;
  logic          fifo_wr;
  logic [W-1:0]  fifo_wdata;
  logic          event_ready;
  logic [CW-1:0] words_taken;
  logic [CW-1:0] event_count;
  logic          truncated;
  logic          auto_trig;
  logic [2:0]    state;

  int checks  = 0;
  int errors  = 0;
  int wr_seen = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  always #5 clk = ~clk;

  acq_trigger #(
    .NSAMP(NSAMP),
    .SW   (SW),
    .CW   (CW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .arm           (arm),
    .trig_type     (trig_type),
    .lower_thresh  (lower_thresh),
    .upper_thresh  (upper_thresh),
    .length_to_take(length_to_take),
    .timeout_cycles(timeout_cycles),
    .fifo_full     (fifo_full),
    .readout_done  (readout_done),
    .fifo_wr       (fifo_wr),
    .fifo_wdata    (fifo_wdata),
    .event_ready   (event_ready),
    .words_taken   (words_taken),
    .event_count   (event_count),
    .truncated     (truncated),
    .auto_trig     (auto_trig),
    .state         (state)
  );

  // Scoreboard monitor: every write must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && fifo_wr) begin
        checks++;
        wr_seen++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fifo_write unexpected: got %h, required no write", fifo_wdata);
        end else begin
          exp_w = exp_q.pop_front();
          if (fifo_wdata !== exp_w) begin
            errors++;
            $display("FAIL fifo_wdata: got %h required %h", fifo_wdata, exp_w);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] samp(input logic [W-1:0] w, input int i, input int v);
    logic [W-1:0] r;
    r = w;
    r[i*SW +: SW] = SW'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] pat(input int seed);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NSAMP); i++) r[i*SW +: SW] = SW'(seed * 37 + i * 5 + 1);
    return r;
  endfunction

  task automatic do_arm(input logic [1:0] t, input int lo, input int hi, input int len);
    trig_type      = t;
    lower_thresh   = SW'(lo);
    upper_thresh   = SW'(hi);
    length_to_take = CW'(len);
    arm            = 1'b1;
    tick();
    arm            = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] w, input logic v, input logic exp_wr);
    s_data  = w;
    s_valid = v;
    if (exp_wr) exp_q.push_back(w);
    tick();
  endtask

  task automatic readout(input string name);
    readout_done = 1'b1;
    tick();
    readout_done = 1'b0;
    chk(name, 32'(state), 0);
    chk({name, "_ready"}, 32'(event_ready), 0);
  endtask

  logic [W-1:0] z;

  initial begin
    z              = '0;
    s_data         = '0;
    s_valid        = 1'b0;
    arm            = 1'b0;
    trig_type      = '0;
    lower_thresh   = '0;
    upper_thresh   = '0;
    length_to_take = '0;
    timeout_cycles = CW'(100);
    fifo_full      = 1'b0;
    readout_done   = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_state", 32'(state), 0);
    chk("rst_fifo_wr", 32'(fifo_wr), 0);
    chk("rst_ready", 32'(event_ready), 0);
    chk("rst_words", 32'(words_taken), 0);
    chk("rst_evcnt", 32'(event_count), 0);
    chk("rst_trunc", 32'(truncated), 0);
    chk("rst_auto", 32'(auto_trig), 0);
    chk("rst_wdata", 32'(|fifo_wdata), 0);
    rstn = 1'b1;
    tick();

    // Immediate trigger, length 3
    s_valid = 1'b1;
    s_data  = pat(0);
    do_arm(TRIG_IMM, 0, 0, 3);
    chk("t1_state_cap", 32'(state), 3);
    send(pat(1), 1'b1, 1'b1);
    send(pat(2), 1'b1, 1'b1);
    send(pat(3), 1'b1, 1'b1);
    chk("t1_words3", 32'(words_taken), 3);
    send(pat(4), 1'b1, 1'b0);
    chk("t1_state_ready", 32'(state), 4);
    chk("t1_ready", 32'(event_ready), 1);
    chk("t1_evcnt", 32'(event_count), 1);
    chk("t1_wr_done", 32'(fifo_wr), 0);
    chk("t1_writes", wr_seen, 3);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("t1_arm_ignored", 32'(state), 4);
    chk("t1_arm_evcnt", 32'(event_count), 1);
    readout("t1_readout");

    // Rising: A at s0, B at s5 in one word -> straight to CAPTURE
    s_valid = 1'b0;
    do_arm(TRIG_RISE, -10, 10, 2);
    chk("t2_wait_a", 32'(state), 1);
    send(samp(samp(z, 0, -20), 5, 30), 1'b0, 1'b0);
    chk("t2_invalid_ignored", 32'(state), 1);
    send(samp(samp(z, 0, -20), 5, 30), 1'b1, 1'b0);
    chk("t2_direct_cap", 32'(state), 3);
    send(pat(10), 1'b1, 1'b1);
    send(pat(11), 1'b1, 1'b1);
    send(pat(12), 1'b1, 1'b0);
    chk("t2_ready", 32'(state), 4);
    chk("t2_evcnt", 32'(event_count), 2);
    chk("t2_words", 32'(words_taken), 2);
    readout("t2_readout");

    // Falling: A word, then a non-B word, then the B word
    s_valid = 1'b0;
    do_arm(TRIG_FALL, -10, 10, 1);
    chk("t3_wait_a", 32'(state), 1);
    send(samp(z, 3, 50), 1'b1, 1'b0);
    chk("t3_wait_b", 32'(state), 2);
    send(samp(z, 0, 50), 1'b1, 1'b0);
    chk("t3_stay_b", 32'(state), 2);
    send(samp(z, 0, -50), 1'b1, 1'b0);
    chk("t3_cap", 32'(state), 3);
    send(pat(20), 1'b1, 1'b1);
    send(pat(21), 1'b1, 1'b0);
    chk("t3_ready", 32'(state), 4);
    chk("t3_evcnt", 32'(event_count), 3);
    readout("t3_readout");

    // Rising with B before A, threshold equality, and length 0
    s_valid = 1'b0;
    do_arm(TRIG_RISE, -10, 10, 0);
    send(samp(samp(z, 0, 30), 5, -20), 1'b1, 1'b0);
    chk("t3b_b_before_a", 32'(state), 2);
    send(samp(z, 4, 10), 1'b1, 1'b0);
    chk("t3b_equal_thresh", 32'(state), 2);
    send(samp(z, 2, 11), 1'b1, 1'b0);
    chk("t3b_cap", 32'(state), 3);
    send(pat(30), 1'b1, 1'b0);
    chk("t3b_len0_ready", 32'(state), 4);
    chk("t3b_len0_words", 32'(words_taken), 0);
    chk("t3b_writes", wr_seen, 6);
    readout("t3b_readout");

    // Truncation: length 8, FIFO full after 5 writes
    s_valid = 1'b1;
    do_arm(TRIG_IMM, 0, 0, 8);
    for (int k = 0; k < 5; k++) send(pat(40 + k), 1'b1, 1'b1);
    fifo_full = 1'b1;
    send(pat(45), 1'b1, 1'b0);
    chk("t4_ready", 32'(state), 4);
    chk("t4_trunc", 32'(truncated), 1);
    chk("t4_words", 32'(words_taken), 5);
    chk("t4_evcnt", 32'(event_count), 5);
    tick();
    chk("t4_no_wr_full", 32'(fifo_wr), 0);
    fifo_full = 1'b0;
    readout("t4_readout");

    // Flat data in WAIT_A with timeout 100
    do_arm(TRIG_RISE, -10, 10, 0);
    chk("t5_wait_a", 32'(state), 1);
    chk("t5_trunc_cleared", 32'(truncated), 0);
    for (int k = 0; k < 99; k++) send(z, 1'b1, 1'b0);
    chk("t5_before_tmo", 32'(state), 1);
    send(z, 1'b1, 1'b0);
`ifdef ACQ_AUTOTRIG_EN
    chk("t5_tmo_cap", 32'(state), 3);
    chk("t5_auto", 32'(auto_trig), 1);
    send(z, 1'b1, 1'b0);
    chk("t5_ready", 32'(state), 4);
    chk("t5_evcnt", 32'(event_count), 6);
`else
    chk("t5_no_tmo", 32'(state), 1);
    chk("t5_auto0", 32'(auto_trig), 0);
`endif

    // Reset at the second write of a capture
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    s_valid = 1'b1;
    do_arm(TRIG_IMM, 0, 0, 5);
    send(pat(50), 1'b1, 1'b1);
    s_data = pat(51);
    tick();
    rstn = 1'b0;
    #1;
    chk("t6_rst_state", 32'(state), 0);
    chk("t6_rst_wr", 32'(fifo_wr), 0);
    chk("t6_rst_words", 32'(words_taken), 0);
    chk("t6_rst_evcnt", 32'(event_count), 0);
    chk("t6_rst_ready", 32'(event_ready), 0);
    chk("t6_rst_wdata", 32'(|fifo_wdata), 0);
    tick();
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) send(pat(60 + k), 1'b1, 1'b0);
    chk("t6_idle_after", 32'(state), 0);
    chk("t6_writes", wr_seen, 12);

    // Event counter wrap
    s_valid        = 1'b0;
    trig_type      = TRIG_IMM;
    length_to_take = '0;
    for (int k = 0; k < (1 << CW) - 1; k++) begin
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
      readout_done = 1'b1;
      tick();
      readout_done = 1'b0;
    end
    chk("t7_evcnt_max", 32'(event_count), (1 << CW) - 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    chk("t7_wrap_ready", 32'(event_ready), 1);
    chk("t7_evcnt_wrap", 32'(event_count), 0);
    readout("t7_readout");

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
